// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Provides the FSM state enum and the divide-by-zero quotient pattern.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  // Widest operand the divider supports.
  localparam int MAX_WIDTH = 64;

  // Quotient reported for a zero divisor: all ones at the widest width.
  // The caller keeps the low WIDTH bits.
  function automatic logic [MAX_WIDTH-1:0] dbz_quotient();
    return '1;
  endfunction

endpackage

// File: rtl/radix2_divider.sv
// Radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
// Latency: result valid after edge WIDTH+1 counted from the accept edge; a zero divisor is reported in the cycle after accept.
// Backpressure: single request in flight; data_ready_out only in IDLE, result held in DONE until data_ready_in.
// Ports: clk_in/rst_in (async active-high); dividend_in/divisor_in/signed_in with data_valid_in/data_ready_out;
//        quotient_out/remainder_out/error_out with data_valid_out/data_ready_in; busy_out high outside IDLE.
module radix2_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  input  logic             signed_in,
  input  logic             data_valid_in,
  output logic             data_ready_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             error_out,
  output logic             data_valid_out,
  input  logic             data_ready_in,
  output logic             busy_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [MAX_WIDTH-1:0] DBZ_FULL = dbz_quotient();
  localparam logic [WIDTH-1:0]     DBZ_Q    = DBZ_FULL[WIDTH-1:0];
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;      // dividend magnitude; quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic [WIDTH-1:0] rem_q;      // partial remainder (always < divisor, so WIDTH bits hold it)
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;
  logic             err_q;

  logic             accept;
  logic             div_zero;
  logic             op_signed;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_shift;
  logic             step_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign accept    = data_valid_in && (state_q == ST_IDLE);
  assign div_zero  = (divisor_in == '0);
  assign op_signed = (SIGNED_EN != 0) && signed_in;
  assign sign_a    = op_signed && dividend_in[WIDTH-1];
  assign sign_b    = op_signed && divisor_in[WIDTH-1];
  // The most-negative value negates to itself, which read unsigned is its true magnitude.
  assign mag_a     = sign_a ? -dividend_in : dividend_in;
  assign mag_b     = sign_b ? -divisor_in  : divisor_in;

  // One restoring step: the shifted remainder needs WIDTH+1 bits; the restored
  // result is below the divisor again, so the subtraction fits in WIDTH bits.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign step_ge   = (rem_shift >= {1'b0, dvs_q});
  assign rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
  assign rem_next  = step_ge ? rem_sub : rem_shift[WIDTH-1:0];

  // Sign fix-up: quotient truncates toward zero, remainder follows the dividend.
  assign quo_fix = neg_quo_q ? -dvd_q : dvd_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = div_zero ? ST_DONE : ST_DIV;
      ST_DIV:  if (cnt_q == CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (data_ready_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    data_ready_out = (state_q == ST_IDLE);
    busy_out       = (state_q != ST_IDLE);
    data_valid_out = (state_q == ST_DONE);
  end

  // Datapath
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q     <= '0;
            dvd_q     <= mag_a;
            dvs_q     <= mag_b;
            rem_q     <= '0;
            neg_quo_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            if (div_zero) begin
              quo_out_q <= DBZ_Q;
              rem_out_q <= dividend_in;
              err_q     <= 1'b1;
            end else begin
              err_q     <= 1'b0;
            end
          end
        end
        ST_DIV: begin
          rem_q <= rem_next;
          dvd_q <= {dvd_q[WIDTH-2:0], step_ge};
          cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
        ST_FIX: begin
          quo_out_q <= quo_fix;
          rem_out_q <= rem_fix;
          err_q     <= 1'b0;
        end
        default: ; // DONE holds the result
      endcase
    end
  end

  assign quotient_out  = quo_out_q;
  assign remainder_out = rem_out_q;
  assign error_out     = err_q;

endmodule

// File: tb/tb_radix2_divider.sv
// Self-checking bench for radix2_divider (WIDTH=32, SIGNED_EN=1).
// Latency: n/a. A scoreboard queue is filled at accept from a plain-arithmetic reference model.
// Backpressure: data_ready_in is driven high, low, or randomly to exercise DONE hold.
module tb_radix2_divider;

  localparam int W = 32;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic [W-1:0] dividend_in;
  logic [W-1:0] divisor_in;
  logic         signed_in;
  logic         data_valid_in;
  logic         data_ready_out;
  logic [W-1:0] quotient_out;
  logic [W-1:0] remainder_out;
  logic         error_out;
  logic         data_valid_out;
  logic         data_ready_in;
  logic         busy_out;

  always #5 clk_in = ~clk_in;

  radix2_divider #(.WIDTH(W), .SIGNED_EN(1)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .dividend_in    (dividend_in),
    .divisor_in     (divisor_in),
    .signed_in      (signed_in),
    .data_valid_in  (data_valid_in),
    .data_ready_out (data_ready_out),
    .quotient_out   (quotient_out),
    .remainder_out  (remainder_out),
    .error_out      (error_out),
    .data_valid_out (data_valid_out),
    .data_ready_in  (data_ready_in),
    .busy_out       (busy_out)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
    int           vcyc;   // posedge count at which valid must first be seen
  } exp_t;

  exp_t scb[$];
  exp_t cur_exp;
  bit   seen = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 2;   // 0 random, 1 held low, 2 held high

  always @(posedge clk_in) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division at 64 bits, which truncates toward zero
  // and gives the remainder the dividend's sign.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int acc);
    exp_t   e;
    longint sa, sbv, qq, rr;
    if (b == '0) begin
      e.q = '1; e.r = a; e.e = 1'b1; e.vcyc = acc;
    end else begin
      if (s) begin sa = $signed(a); sbv = $signed(b); end
      else   begin sa = a;          sbv = b;          end
      qq = sa / sbv;
      rr = sa % sbv;
      e.q = qq[W-1:0]; e.r = rr[W-1:0]; e.e = 1'b0; e.vcyc = acc + W + 1;
    end
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, output int acc);
    bit ok = 0;
    dividend_in = a; divisor_in = b; signed_in = s; data_valid_in = 1'b1;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      if (data_ready_out) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got ready=0 expected ready=1 within 300 cycles");
    end else begin
      acc = cyc + 1;
      scb.push_back(model(a, b, s, acc));
    end
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      if (data_ready_out && !data_valid_out) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy expected idle within 300 cycles");
    end
  endtask

  // Downstream ready, changed just after each rising edge.
  initial begin
    data_ready_in = 1'b0;
    forever begin
      @(posedge clk_in); #1;
      case (rdy_mode)
        0:       data_ready_in = ($urandom_range(0, 3) != 0);
        1:       data_ready_in = 1'b0;
        default: data_ready_in = 1'b1;
      endcase
    end
  end

  // Monitor: pops on the first valid cycle of each result and re-checks every
  // held cycle against the same expectation.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (data_valid_out) begin
        if (!seen) begin
          if (scb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got q=0x%0h expected no result", quotient_out);
          end else begin
            cur_exp = scb.pop_front();
            chk("latency", cyc, cur_exp.vcyc);
          end
          seen = 1;
        end
        chk("quotient", quotient_out, cur_exp.q);
        chk("remainder", remainder_out, cur_exp.r);
        chk("error", error_out, cur_exp.e);
        if (data_ready_in) seen = 0;
      end else if (seen) begin
        checks++; errors++;
        $display("FAIL valid_dropped: got valid=0 expected valid=1 until accepted");
        seen = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dcyc;
    logic [W-1:0] a, b;
    dividend_in = '0; divisor_in = '0; signed_in = 1'b0; data_valid_in = 1'b0;

    // Reset applies without a clock edge.
    #2 rst_in = 1'b1;
    #1;
    chk("rst_valid", data_valid_out, 0);
    chk("rst_ready", data_ready_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_quotient", quotient_out, 0);
    chk("rst_remainder", remainder_out, 0);
    chk("rst_error", error_out, 0);
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    dcyc = cyc;

    // Directed cases; first one must be taken on the first edge after reset.
    issue(32'd100, 32'd7, 1'b0, acc);
    chk("first_accept_edge", acc, dcyc + 1);
    issue(-32'sd7, 32'd2, 1'b1, acc);
    issue(32'd7, -32'sd2, 1'b1, acc);
    issue(32'h1234, 32'h0, 1'b1, acc);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, acc);

    // Hold in DONE for 10 cycles while a request is offered; it must not be taken.
    wait_idle();
    rdy_mode = 1;
    @(posedge clk_in); #1;
    issue(32'd1000, 32'd3, 1'b0, acc);
    begin
      bit got = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_in);
        if (data_valid_out) begin got = 1; break; end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL done_timeout: got valid=0 expected valid=1");
      end
    end
    @(posedge clk_in); #1;
    dividend_in = 32'd55; divisor_in = 32'd5; data_valid_in = 1'b1;
    repeat (10) begin
      @(negedge clk_in);
      chk("no_accept_in_done", data_ready_out, 0);
      @(posedge clk_in); #1;
    end
    data_valid_in = 1'b0;
    rdy_mode = 2;

    // A request pulsed during DIV is dropped.
    issue(32'hDEAD_BEEF, 32'h0000_1357, 1'b0, acc);
    repeat (4) @(posedge clk_in);
    #1;
    dividend_in = 32'd99; divisor_in = 32'd9; data_valid_in = 1'b1;
    @(negedge clk_in);
    chk("busy_in_div", busy_out, 1);
    chk("no_accept_in_div", data_ready_out, 0);
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;

    // Reset in the middle of a division, after 16 iterations.
    issue(32'h0FED_CBA9, 32'h0000_0031, 1'b0, acc);
    repeat (16) @(posedge clk_in);
    #3 rst_in = 1'b1;
    #1;
    scb.delete();
    seen = 0;
    chk("midrst_valid", data_valid_out, 0);
    chk("midrst_ready", data_ready_out, 1);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_quotient", quotient_out, 0);
    chk("midrst_remainder", remainder_out, 0);
    chk("midrst_error", error_out, 0);
    @(posedge clk_in); #1 rst_in = 1'b0;
    dcyc = cyc;
    issue(32'd123456789, 32'd1000, 1'b0, acc);
    chk("accept_after_midrst", acc, dcyc + 1);

    // Randomized traffic with random downstream backpressure.
    rdy_mode = 0;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2, 3: begin
          b = $urandom_range(1, 20);
          if ($urandom_range(0, 1) != 0) b = -b;
        end
        default: b = $urandom;
      endcase
      issue(a, b, $urandom_range(0, 1) != 0, acc);
    end

    // Drain and confirm nothing is left outstanding.
    rdy_mode = 2;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_in);
      if (scb.size() == 0 && !data_valid_out && !seen) break;
    end
    chk("drain_empty", scb.size(), 0);
    repeat (5) @(posedge clk_in);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
